// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply engine.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN
  } sa_state_e;

  function automatic int comp_cycles(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell: forwards A right and B down, one hop per cycle.
module sa_pe #(
  parameter int DW     = 8,
  parameter int AW     = 18,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [AW-1:0] acc_o
);

  logic          ea;
  logic          eb;
  logic [AW-1:0] ax;
  logic [AW-1:0] bx;
  logic [AW-1:0] prod;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [AW-1:0] acc_q;

  // Low AW bits of the extended product are exact for both modes.
  always_comb begin
    ea   = (SIGNED != 0) && a_i[DW-1];
    eb   = (SIGNED != 0) && b_i[DW-1];
    ax   = {{(AW-DW){ea}}, a_i};
    bx   = {{(AW-DW){eb}}, b_i};
    prod = ax * bx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (en_i) begin
        acc_q <= (clr_i ? '0 : acc_q) + prod;
      end
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matmul: buffered load, skewed compute,
// back-pressured row-major drain.
module systolic_mm_engine
  import sa_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = 2 * DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int COMP_CYCLES = comp_cycles(N);
  localparam int CW  = cnt_w(N);
  localparam int CCW = cnt_w(COMP_CYCLES);
  localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
  localparam logic [CCW-1:0] LAST_CYC = CCW'(COMP_CYCLES - 1);

  sa_state_e      state_q;
  logic           clr_q;
  logic           in_ready_q;
  logic           busy_q;
  logic           done_q;
  logic           out_valid_q;
  logic           out_last_q;
  logic [AW-1:0]  out_data_q;
  logic [CW-1:0]  lr_q;
  logic [CW-1:0]  lc_q;
  logic [CW-1:0]  dr_q;
  logic [CW-1:0]  dc_q;
  logic [CCW-1:0] cyc_q;

  logic [DW-1:0] a_buf_q [N][N];
  logic [DW-1:0] b_buf_q [N][N];
  logic [DW-1:0] a_inj [N];
  logic [DW-1:0] b_inj [N];
  logic [DW-1:0] a_pipe [N][N-1];
  logic [DW-1:0] b_pipe [N-1][N];
  logic [DW-1:0] a_edge_unused [N];
  logic [DW-1:0] b_edge_unused [N];
  logic [AW-1:0] acc_w [N][N];
  logic          pe_en;
  logic          pe_clr;

  assign pe_en  = (state_q == COMPUTE);
  assign pe_clr = pe_en && clr_q && (cyc_q == '0);

  // Edge i/j carries element k = c - i (or c - j) while it lies in 0..N-1.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (pe_en && (cyc_q == CCW'(i + k))) begin
          a_inj[i] = a_buf_q[i][k];
          b_inj[i] = b_buf_q[k][i];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_src;
      logic [DW-1:0] b_src;
      logic [DW-1:0] a_nxt;
      logic [DW-1:0] b_nxt;

      if (j == 0) begin : g_aw
        assign a_src = a_inj[i];
      end else begin : g_aw
        assign a_src = a_pipe[i][j-1];
      end

      if (i == 0) begin : g_bn
        assign b_src = b_inj[j];
      end else begin : g_bn
        assign b_src = b_pipe[i-1][j];
      end

      if (j < N - 1) begin : g_ae
        assign a_pipe[i][j] = a_nxt;
      end else begin : g_ae
        assign a_edge_unused[i] = a_nxt;
      end

      if (i < N - 1) begin : g_be
        assign b_pipe[i][j] = b_nxt;
      end else begin : g_be
        assign b_edge_unused[j] = b_nxt;
      end

      sa_pe #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pe_en),
        .clr_i (pe_clr),
        .a_i   (a_src),
        .b_i   (b_src),
        .a_o   (a_nxt),
        .b_o   (b_nxt),
        .acc_o (acc_w[i][j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      lr_q        <= '0;
      lc_q        <= '0;
      dr_q        <= '0;
      dc_q        <= '0;
      cyc_q       <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_buf_q[i][j] <= '0;
          b_buf_q[i][j] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            clr_q      <= acc_clear;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            lr_q       <= '0;
            lc_q       <= '0;
          end
        end
        LOAD: begin
          if (in_valid && in_ready_q) begin
            a_buf_q[lr_q][lc_q] <= a_in;
            b_buf_q[lc_q][lr_q] <= b_in;
            if (lc_q == LAST_IDX) begin
              lc_q <= '0;
              if (lr_q == LAST_IDX) begin
                state_q    <= COMPUTE;
                in_ready_q <= 1'b0;
                cyc_q      <= '0;
              end else begin
                lr_q <= lr_q + CW'(1);
              end
            end else begin
              lc_q <= lc_q + CW'(1);
            end
          end
        end
        COMPUTE: begin
          if (cyc_q == LAST_CYC) begin
            state_q <= DRAIN;
            dr_q    <= '0;
            dc_q    <= '0;
          end else begin
            cyc_q <= cyc_q + CCW'(1);
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready && out_last_q) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (!out_valid_q || out_ready) begin
            // Output register refills only when empty or being consumed.
            out_data_q  <= acc_w[dr_q][dc_q];
            out_last_q  <= (dr_q == LAST_IDX) && (dc_q == LAST_IDX);
            out_valid_q <= 1'b1;
            if (dc_q == LAST_IDX) begin
              dc_q <= '0;
              dr_q <= dr_q + CW'(1);
            end else begin
              dc_q <= dc_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed and randomised-stall checks of systolic_mm_engine against a plain
// matrix-multiply model, unsigned and signed instances driven in lockstep.
module tb_systolic_mm_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          acc_clear;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;

  logic          u_in_ready, u_out_valid, u_out_last, u_busy, u_done;
  logic [AW-1:0] u_out_data;
  logic          s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic [AW-1:0] s_out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_u = 0;
  int last_beat_cyc;

  int            hand_on;
  int            hand_step;
  logic [AW-1:0] hand_u;
  logic [AW-1:0] hand_s;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [AW-1:0] exp_u [N][N];
  logic [AW-1:0] exp_s [N][N];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_done) done_u <= done_u + 1;
  end

  systolic_mm_engine #(.N(N), .DW(DW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear),
    .in_valid(in_valid), .in_ready(u_in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_last(u_out_last), .busy(u_busy), .done(u_done)
  );

  systolic_mm_engine #(.N(N), .DW(DW), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy), .done(s_done)
  );

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_u[i][j] = '0;
        exp_s[i][j] = '0;
      end
  endtask

  task automatic update_model(input bit clr);
    int su, ss;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        su = 0;
        ss = 0;
        for (int k = 0; k < N; k++) begin
          su += int'(ma[i][k]) * int'(mb[k][j]);
          ss += int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
        end
        exp_u[i][j] = (clr ? '0 : exp_u[i][j]) + AW'(su);
        exp_s[i][j] = (clr ? '0 : exp_s[i][j]) + AW'(ss);
      end
  endtask

  task automatic start_job(input bit clr);
    start     = 1'b1;
    acc_clear = clr;
    @(negedge clk);
    start     = 1'b0;
    acc_clear = 1'b0;
    checks++;
    if (u_busy !== 1'b1 || u_in_ready !== 1'b1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%b in_ready=%b required 1 1",
               u_busy, u_in_ready);
    end
  endtask

  task automatic load(input int gap);
    int t, g;
    bit r;
    t = 0;
    g = 0;
    while (t < N * N && g < 3000) begin
      r = u_in_ready;
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        a_in     = DW'($urandom);
        b_in     = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        a_in     = ma[t / N][t % N];
        b_in     = mb[t % N][t / N];
      end
      @(negedge clk);
      g++;
      if (in_valid && r) t++;
    end
    in_valid      = 1'b0;
    last_beat_cyc = cyc;
    checks++;
    if (t != N * N) begin
      errors++;
      $display("FAIL load_timeout: beats=%0d required %0d", t, N * N);
    end
    checks++;
    if (u_in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_drop: in_ready=%b required 0", u_in_ready);
    end
  endtask

  task automatic drain(input int stall, input bit chk_lat);
    int k, g;
    bit ov, ol, sv, sl, held, first;
    logic [AW-1:0] od, sd, hold_d;
    bit hold_l;
    k     = 0;
    g     = 0;
    held  = 0;
    first = 1;
    hold_d = '0;
    hold_l = 0;
    while (k < N * N && g < 3000) begin
      ov = u_out_valid; od = u_out_data; ol = u_out_last;
      sv = s_out_valid; sd = s_out_data; sl = s_out_last;
      if (held) begin
        checks++;
        if (ov !== 1'b1 || od !== hold_d || ol !== hold_l) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%0h required 1 %0h",
                   ov, od, hold_d);
        end
      end
      if (ov && first) begin
        first = 0;
        if (chk_lat) begin
          checks++;
          if (cyc != last_beat_cyc + 3 * N - 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d",
                     cyc - last_beat_cyc, 3 * N - 1);
          end
        end
      end
      out_ready = (stall > 0 && $urandom_range(99) < stall) ? 1'b0 : 1'b1;
      held   = ov && !out_ready;
      hold_d = od;
      hold_l = ol;
      @(negedge clk);
      g++;
      if (ov && out_ready) begin
        checks++;
        if (od !== exp_u[k / N][k % N] || ol !== (k == N * N - 1) ||
            sv !== 1'b1 || sl !== ol) begin
          errors++;
          $display("FAIL data_u beat %0d: data=%0h last=%b required %0h %b",
                   k, od, ol, exp_u[k / N][k % N], k == N * N - 1);
        end
        checks++;
        if (sd !== exp_s[k / N][k % N]) begin
          errors++;
          $display("FAIL data_s beat %0d: data=%0h required %0h",
                   k, sd, exp_s[k / N][k % N]);
        end
        if (hand_on == 1) begin
          checks++;
          if (od !== AW'((k + 1) * hand_step)) begin
            errors++;
            $display("FAIL hand_seq beat %0d: data=%0d required %0d",
                     k, od, (k + 1) * hand_step);
          end
        end else if (hand_on == 2) begin
          checks++;
          if (od !== hand_u || sd !== hand_s) begin
            errors++;
            $display("FAIL hand_const beat %0d: u=%0h s=%0h required %0h %0h",
                     k, od, sd, hand_u, hand_s);
          end
        end
        k++;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (k != N * N) begin
      errors++;
      $display("FAIL drain_timeout: beats=%0d required %0d", k, N * N);
    end
    checks++;
    if (u_done !== 1'b1 || u_busy !== 1'b0 || s_done !== 1'b1 ||
        u_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b required 1 0 0",
               u_done, u_busy, u_out_valid);
    end
  endtask

  task automatic run_job(input bit clr, input int gap, input int stall,
                         input bit chk_lat);
    update_model(clr);
    start_job(clr);
    load(gap);
    drain(stall, chk_lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; acc_clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({u_in_ready, u_out_valid, u_out_last, u_busy, u_done} !== 5'b0 ||
        u_out_data !== '0) begin
      errors++;
      $display("FAIL reset_u: flags=%b data=%0h required 0 0",
               {u_in_ready, u_out_valid, u_out_last, u_busy, u_done}, u_out_data);
    end
    checks++;
    if ({s_in_ready, s_out_valid, s_out_last, s_busy, s_done} !== 5'b0 ||
        s_out_data !== '0) begin
      errors++;
      $display("FAIL reset_s: flags=%b data=%0h required 0 0",
               {s_in_ready, s_out_valid, s_out_last, s_busy, s_done}, s_out_data);
    end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 8'd1 : 8'd0;
        mb[i][j] = DW'(N * i + j + 1);
      end
  endtask

  task automatic test_identity();
    int d0;
    set_identity();
    hand_on = 1; hand_step = 1;
    d0 = done_u;
    run_job(1'b1, 0, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (u_done !== 1'b0 || done_u != d0 + 1) begin
      errors++;
      $display("FAIL done_once: done=%b pulses=%0d required 0 1",
               u_done, done_u - d0);
    end
  endtask

  task automatic test_accumulate();
    set_identity();
    hand_on = 1; hand_step = 2;
    run_job(1'b0, 0, 0, 1'b1);
    hand_step = 1;
    run_job(1'b1, 0, 0, 1'b1);
  endtask

  task automatic test_signed();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 8'hFF;
        mb[i][j] = 8'h02;
      end
    hand_on = 2; hand_u = 18'd2040; hand_s = 18'h3FFF8;
    run_job(1'b1, 0, 0, 1'b1);
  endtask

  task automatic test_max();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 8'hFF;
        mb[i][j] = 8'hFF;
      end
    hand_on = 2; hand_u = 18'd260100; hand_s = 18'd4;
    run_job(1'b1, 0, 0, 1'b1);
  endtask

  task automatic randomise_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = DW'($urandom);
        mb[i][j] = DW'($urandom);
      end
  endtask

  task automatic test_back_to_back_stalls();
    hand_on = 0;
    for (int n = 0; n < 200; n++) begin
      randomise_mats();
      run_job((n == 0) || ($urandom_range(3) == 0), 30, 35, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    hand_on = 0;
    randomise_mats();
    @(negedge clk);
    d0 = done_u;
    start_job(1'b1);
    load(0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (u_busy !== 1'b0 || u_out_valid !== 1'b0 || u_done !== 1'b0 ||
        s_busy !== 1'b0 || u_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b done=%b required 0 0 0",
               u_busy, u_out_valid, u_done);
    end
    @(negedge clk);
    checks++;
    if (done_u != d0) begin
      errors++;
      $display("FAIL reset_no_done: pulses=%0d required 0", done_u - d0);
    end
    clear_model();
    randomise_mats();
    run_job(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    hand_on = 0; hand_step = 0; hand_u = '0; hand_s = '0;
    test_reset();
    test_identity();
    test_accumulate();
    test_signed();
    test_max();
    test_back_to_back_stalls();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine, the successor of the fixed 4×4 wrapper. It accepts paired A/B operand streams through a valid/ready port and buffers them internally. It then drives them skewed into an N×N grid of MAC cells and drains the N² results through a back-pressured valid/ready port. It sits as a coprocessor beside the host datapath. Over the fixed design it adds signed mode, cross-job accumulation for K-tiling, and output back-pressure.

## Interface
- N, 4, array dimension (rows = cols = inner dimension K); N ≥ 2
- DW, 8, operand width
- AW, 2*DW+$clog2(N), accumulator/result width
- SIGNED, 0, 1 = operands and accumulators are two's complement
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request; sampled only in IDLE
- acc_clear  in  1  sampled with start; 1 = zero accumulators before compute, 0 = add onto previous results
- in_valid  in  1  a_in/b_in beat valid
- in_ready  out  1  engine accepts a beat (high only in LOAD)
- a_in  in  DW  A element
- b_in  in  DW  B element
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts result
- out_data  out  AW  C element
- out_last  out  1  marks final result beat (C[N-1][N-1])
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when job completes

## Operation
- FSM: IDLE → LOAD → COMPUTE → DRAIN → IDLE.
- IDLE: start=1 → LOAD. Latch acc_clear. start outside IDLE is ignored.
- LOAD: accepts N² beats; a beat transfers when in_valid & in_ready. Beat t carries A[t/N][t%N] (row-major) and B[t%N][t/N] (column-major: column j, index k). in_valid low stalls without loss. After beat N²-1 → COMPUTE.
- COMPUTE: exactly 3N-2 cycles, c = 0..3N-3.
  - Row edge i injects A[i][c-i] when 0 ≤ c-i < N, otherwise 0.
  - Column edge j injects B[c-j][j] likewise.
  - Operands register one hop per cycle rightward (A) and downward (B).
  - PE(i,j) performs its MAC for index k at cycle i+j+k.
  - If the latched acc_clear=1, all accumulators are zeroed at c=0, concurrently with the first MAC, which overwrites.
- DRAIN: emits C[i][j] row-major, N² beats. A beat transfers when out_valid & out_ready. out_last is high with beat N²-1. After the last transfer → IDLE.
- Arithmetic:
  - Products are DW×DW, sign- or zero-extended per SIGNED, summed into AW bits.
  - Overflow wraps modulo 2^AW with no saturation.
  - Accumulators persist across jobs until rst or acc_clear=1.
- Unsigned N=4, DW=8: 4·255² = 260100 < 2^18, so the default AW never overflows within one job.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0. State=IDLE; operand buffers, skew registers and accumulators are all 0.
- start sampled at edge e → busy=1 and in_ready=1 from e+1.
- in_ready drops in the cycle after the final LOAD beat is accepted.
- Zero-stall latency, last input beat to first out_valid: 3N-1 cycles (COMPUTE of 3N-2 cycles, plus 1).
- out_data/out_last are held stable while out_valid=1 and out_ready=0.
- done pulses in the cycle after the last DRAIN transfer, coincident with busy=0. A start in that same cycle is accepted.
- rst mid-job (any state): at the next edge, return to IDLE with reset values. A partial job is discarded with no done.
- Minimum job length, no stalls: 1 + N² + (3N-2) + N² cycles.

## Structure
- Package sa_pkg:
  - state enum (IDLE, LOAD, COMPUTE, DRAIN);
  - localparams LOAD_BEATS = N*N, COMP_CYCLES = 3*N-2;
  - counter widths via $clog2.
- Sub-module sa_pe holds one MAC cell:
  - ports: a/b in, a/b out (registered), en, clr, acc out;
  - parametrised DW, AW, SIGNED.
- Top level holds the FSM, beat/cycle counters, the two N×N operand buffers, the skew muxes, the generate-loop PE grid and the row-major result mux.

## Test plan
- Identity: N=4 unsigned, A=I, B=[1..16] row-major, acc_clear=1 → out_data sequence 1..16. out_last on beat 16. Exactly one done pulse.
- Accumulate: repeat the same job with acc_clear=0 → outputs 2,4,…,32. A third job with acc_clear=1 → 1..16 again.
- Signed: SIGNED=1, A all 0xFF (-1), B all 0x02 → every C = -8 (AW=18: 0x3FFF8).
- Max magnitude: unsigned, A=B all 0xFF → every C = 260100, with no wrap.
- Stalls: randomised in_valid gaps and random out_ready=0 cycles over 200 jobs.
  - Results must match the golden model and be in order.
  - out_data must stay stable while stalled.
- Reset mid-job: assert rst at COMPUTE cycle 5 → next cycle busy=0 and out_valid=0, with no done. A fresh job with acc_clear=0 yields pure A×B, proving the accumulators were cleared.
